// File: rtl/left_shift_stream_ctrl_if.sv
// rtl/left_shift_stream_ctrl_if.sv - command, input-word and result streams of the wide left shifter
// slave faces the controller, master faces the issuing/consuming logic.
interface left_shift_stream_ctrl_if #(
   parameter int WORD_WIDTH = 32
) ();
   localparam int SW = $clog2(WORD_WIDTH);

   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [SW-1:0]         cmd_shift_i;
   logic                  cmd_extend_i;

   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [WORD_WIDTH-1:0] in_data_i;
   logic                  in_last_i;

   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [WORD_WIDTH-1:0] out_data_o;
   logic                  out_last_o;
   logic                  out_cf_o;

   logic                  busy_o;

   modport slave (
      input  cmd_valid_i, cmd_shift_i, cmd_extend_i,
      input  in_valid_i, in_data_i, in_last_i,
      input  out_ready_i,
      output cmd_ready_o, in_ready_o,
      output out_valid_o, out_data_o, out_last_o, out_cf_o,
      output busy_o
   );

   modport master (
      output cmd_valid_i, cmd_shift_i, cmd_extend_i,
      output in_valid_i, in_data_i, in_last_i,
      output out_ready_i,
      input  cmd_ready_o, in_ready_o,
      input  out_valid_o, out_data_o, out_last_o, out_cf_o,
      input  busy_o
   );
endinterface

// File: rtl/left_shift_stream_ctrl.sv
// rtl/left_shift_stream_ctrl.sv - word-serial multi-precision left shift built around one left_shift_unit
// Operand words arrive lowest first; bits leaving word k-1 fill the low end of word k.

module left_shift_unit #(
   parameter int WORD_WIDTH = 32,
   localparam int SW = $clog2(WORD_WIDTH)
) (
   input  logic [WORD_WIDTH-1:0] a_i,
   input  logic [SW-1:0]         b_i,
   input  logic [1:0]            op_i,
   input  logic [WORD_WIDTH-2:0] c_i,
   output logic [WORD_WIDTH-1:0] y_o,
   output logic                  cf_o
);
   logic [WORD_WIDTH-1:0]   fill;
   logic [2*WORD_WIDTH-1:0] wide;
   logic [WORD_WIDTH:0]     carry_wide;

   // op 00 chains from c_i, 01 zero fill, 10 ones fill, 11 rotate
   always_comb begin
      fill = '0;
      unique case (op_i)
         2'b00:   fill = {c_i, 1'b0};
         2'b01:   fill = '0;
         2'b10:   fill = '1;
         default: fill = a_i;
      endcase
      wide       = {a_i, fill} << b_i;
      carry_wide = {1'b0, a_i} << b_i;
      y_o        = wide[2*WORD_WIDTH-1:WORD_WIDTH];
      cf_o       = carry_wide[WORD_WIDTH];
   end
endmodule

module left_shift_stream_ctrl #(
   parameter int         WORD_WIDTH = 32,
   parameter logic [1:0] OP_CHAIN   = 2'b00,
   localparam int        SW         = $clog2(WORD_WIDTH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   left_shift_stream_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_EXT  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  out_valid_q, out_valid_d;
   logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  out_cf_q, out_cf_d;
   logic [SW-1:0]         shift_q, shift_d;
   logic                  extend_q, extend_d;
   // Only the upper WORD_WIDTH-1 bits of the previous word can ever reach the next one.
   logic [WORD_WIDTH-2:0] prev_hi_q, prev_hi_d;

   logic                  out_free;
   logic                  cmd_fire;
   logic                  in_fire;
   logic [WORD_WIDTH-1:0] sh_a;
   logic [WORD_WIDTH-1:0] sh_y;
   logic                  sh_cf;

   assign out_free = !out_valid_q || bus.out_ready_i;
   assign bus.cmd_ready_o = (state_q == S_IDLE);
   assign bus.in_ready_o  = (state_q == S_RUN) && out_free;
   assign cmd_fire = bus.cmd_valid_i && bus.cmd_ready_o;
   assign in_fire  = bus.in_valid_i && bus.in_ready_o;
   assign sh_a     = (state_q == S_EXT) ? '0 : bus.in_data_i;

   left_shift_unit #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_shift (
      .a_i  (sh_a),
      .b_i  (shift_q),
      .op_i (OP_CHAIN),
      .c_i  (prev_hi_q),
      .y_o  (sh_y),
      .cf_o (sh_cf)
   );

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_cf_d    = out_cf_q;
      shift_d     = shift_q;
      extend_d    = extend_q;
      prev_hi_d   = prev_hi_q;

      if (out_valid_q && bus.out_ready_i) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               shift_d   = bus.cmd_shift_i;
               extend_d  = bus.cmd_extend_i;
               prev_hi_d = '0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            if (in_fire) begin
               out_valid_d = 1'b1;
               out_data_d  = sh_y;
               out_cf_d    = sh_cf;
               prev_hi_d   = bus.in_data_i[WORD_WIDTH-1:1];
               if (bus.in_last_i) begin
                  out_last_d = !extend_q;
                  state_d    = extend_q ? S_EXT : S_IDLE;
               end else begin
                  out_last_d = 1'b0;
               end
            end
         end
         S_EXT: begin
            // With a_i forced to zero the shifter yields just the spill of the top word.
            if (out_free) begin
               out_valid_d = 1'b1;
               out_data_d  = sh_y;
               out_last_d  = 1'b1;
               out_cf_d    = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_cf_q    <= 1'b0;
         shift_q     <= '0;
         extend_q    <= 1'b0;
         prev_hi_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_cf_q    <= out_cf_d;
         shift_q     <= shift_d;
         extend_q    <= extend_d;
         prev_hi_q   <= prev_hi_d;
      end
   end

   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.out_last_o  = out_last_q;
   assign bus.out_cf_o    = out_cf_q;
   assign bus.busy_o      = (state_q != S_IDLE) || out_valid_q;

   // A stalled result beat must not change under the consumer.
   a_out_stable : assert property (
      @(posedge clk_i) disable iff (rst_i)
      (out_valid_q && !bus.out_ready_i) |=>
         (out_valid_q && $stable(out_data_q) && $stable(out_last_q) && $stable(out_cf_q))
   );
endmodule

// File: tb/tb_left_shift_stream_ctrl.sv
// tb/tb_left_shift_stream_ctrl.sv - randomized and directed bench for left_shift_stream_ctrl (WORD_WIDTH 8)
// Expected beats come from shifting the whole operand as one integer.
module tb_left_shift_stream_ctrl;
   logic clk;
   logic rst;

   left_shift_stream_ctrl_if #(.WORD_WIDTH(8)) bus ();

   left_shift_stream_ctrl #(.WORD_WIDTH(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] words[8];
   logic [7:0] got_data[$];
   bit         got_last[$];
   bit         got_cf[$];
   logic [7:0] exp_data[$];
   bit         exp_last[$];
   bit         exp_cf[$];
   bit         timed_out;

   task automatic drive_idle();
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_shift_i  = '0;
      bus.cmd_extend_i = 1'b0;
      bus.in_valid_i   = 1'b0;
      bus.in_data_i    = '0;
      bus.in_last_i    = 1'b0;
      bus.out_ready_i  = 1'b1;
   endtask

   // Whole operand value shifted left by s; beat k is byte k of the result.
   task automatic build_model(input int s, input bit ext, input int n);
      longint unsigned val = 0;
      longint unsigned sh;
      exp_data.delete(); exp_last.delete(); exp_cf.delete();
      for (int k = 0; k < n; k++) val = val | (64'(words[k]) << (8 * k));
      sh = val << s;
      for (int k = 0; k < n; k++) begin
         exp_data.push_back(8'(sh >> (8 * k)));
         exp_last.push_back((k == n - 1) && !ext);
         exp_cf.push_back((s > 0) ? 1'((val >> (8 * k + 8 - s)) & 64'd1) : 1'b0);
      end
      if (ext) begin
         exp_data.push_back(8'(sh >> (8 * n)));
         exp_last.push_back(1'b1);
         exp_cf.push_back(1'b0);
      end
   endtask

   // Issues one command and its n words with random gaps, collecting result beats until last.
   task automatic run_op(input int s, input bit ext, input int n, input int rdy_pct, input int vld_pct);
      int  idx = 0;
      int  cyc = 0;
      bit  cmd_done = 0;
      bit  done = 0;
      got_data.delete(); got_last.delete(); got_cf.delete();
      timed_out = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.out_ready_i  = ($urandom_range(99) < rdy_pct);
         bus.cmd_valid_i  = !cmd_done;
         bus.cmd_shift_i  = 3'(s);
         bus.cmd_extend_i = ext;
         if (cmd_done && idx < n && $urandom_range(99) < vld_pct) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = words[idx];
            bus.in_last_i  = (idx == n - 1);
         end else begin
            bus.in_valid_i = !cmd_done && $urandom_range(1) == 1;
            bus.in_data_i  = 8'($urandom);
            bus.in_last_i  = 1'($urandom);
         end
         #1;
         if (bus.out_valid_o && bus.out_ready_i) begin
            got_data.push_back(bus.out_data_o);
            got_last.push_back(bus.out_last_o);
            got_cf.push_back(bus.out_cf_o);
            if (bus.out_last_o) done = 1;
         end
         if (cmd_done && bus.in_valid_i && bus.in_ready_o) idx++;
         if (bus.cmd_valid_i && bus.cmd_ready_o) cmd_done = 1;
      end
      if (!done) timed_out = 1;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus.out_valid_o, bus.out_last_o, bus.out_cf_o, bus.busy_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags valid/last/cf/busy=%b required 0000",
                  {bus.out_valid_o, bus.out_last_o, bus.out_cf_o, bus.busy_o});
      end
      checks++;
      if (bus.out_data_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got %h required 00", bus.out_data_o);
      end
      checks++;
      if ({bus.cmd_ready_o, bus.in_ready_o} !== 2'b10) begin
         errors++;
         $display("FAIL reset_ready cmd/in=%b required 10", {bus.cmd_ready_o, bus.in_ready_o});
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [7:0] ed[3];
      bit         el[3];
      bit         ec[3];
      int         en, s, n;
      bit         ext;
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: begin s = 0; ext = 0; n = 2; words[0] = 8'h12; words[1] = 8'h34; en = 2;
                  ed = '{8'h12, 8'h34, 8'h00}; el = '{0, 1, 0}; ec = '{0, 0, 0}; end
            1: begin s = 4; ext = 1; n = 2; words[0] = 8'hAB; words[1] = 8'hCD; en = 3;
                  ed = '{8'hB0, 8'hDA, 8'h0C}; el = '{0, 0, 1}; ec = '{0, 0, 0}; end
            2: begin s = 1; ext = 0; n = 1; words[0] = 8'h80; en = 1;
                  ed = '{8'h00, 8'h00, 8'h00}; el = '{1, 0, 0}; ec = '{1, 0, 0}; end
            default: begin s = 7; ext = 1; n = 1; words[0] = 8'hFF; en = 2;
                  ed = '{8'h80, 8'h7F, 8'h00}; el = '{0, 1, 0}; ec = '{1, 0, 0}; end
         endcase
         run_op(s, ext, n, 100, 100);
         checks++;
         if (timed_out || got_data.size() != en) begin
            errors++;
            $display("FAIL directed%0d_count got %0d beats required %0d", c, got_data.size(), en);
         end else begin
            for (int i = 0; i < en; i++) begin
               checks++;
               if ({got_data[i], got_last[i], got_cf[i]} !== {ed[i], el[i], ec[i]}) begin
                  errors++;
                  $display("FAIL directed%0d_beat%0d data/last/cf %h/%b/%b required %h/%b/%b",
                           c, i, got_data[i], got_last[i], got_cf[i], ed[i], el[i], ec[i]);
               end
            end
         end
         if (c == 2) begin
            @(negedge clk);
            bus.cmd_valid_i = 1'b0;
            bus.in_valid_i  = 1'b0;
            #1;
            checks++;
            if ({bus.cmd_ready_o, bus.out_valid_o} !== 2'b10) begin
               errors++;
               $display("FAIL single_word_idle cmd_ready/out_valid=%b required 10",
                        {bus.cmd_ready_o, bus.out_valid_o});
            end
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         int s   = $urandom_range(7);
         bit ext = 1'($urandom);
         int n   = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) words[k] = 8'($urandom);
         build_model(s, ext, n);
         run_op(s, ext, n, $urandom_range(30, 100), $urandom_range(30, 100));
         checks++;
         if (timed_out || got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL random%0d_count got %0d beats required %0d (s=%0d ext=%0d)",
                     t, got_data.size(), exp_data.size(), s, ext);
         end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
               checks++;
               if ({got_data[i], got_last[i], got_cf[i]} !== {exp_data[i], exp_last[i], exp_cf[i]}) begin
                  errors++;
                  $display("FAIL random%0d_beat%0d data/last/cf %h/%b/%b required %h/%b/%b (s=%0d)",
                           t, i, got_data[i], got_last[i], got_cf[i],
                           exp_data[i], exp_last[i], exp_cf[i], s);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int         n = 5;
      int         idx = 0;
      int         cyc = 0;
      int         stall = 0;
      bit         done = 0;
      logic [7:0] held = '0;
      for (int k = 0; k < n; k++) words[k] = 8'($urandom);
      build_model(3, 1, n);
      got_data.delete(); got_last.delete(); got_cf.delete();
      @(negedge clk);
      drive_idle();
      bus.cmd_valid_i  = 1'b1;
      bus.cmd_shift_i  = 3'd3;
      bus.cmd_extend_i = 1'b1;
      #1;
      checks++;
      if (bus.cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_cmd_ready got %b required 1", bus.cmd_ready_o);
      end
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      while (!done && cyc < 200) begin
         bit stalling;
         if (cyc > 0) @(negedge clk);
         cyc++;
         stalling = (got_data.size() == 2 && stall < 3);
         bus.out_ready_i = !stalling;
         bus.in_valid_i  = (idx < n);
         bus.in_data_i   = (idx < n) ? words[idx] : 8'h00;
         bus.in_last_i   = (idx == n - 1);
         #1;
         if (stalling) begin
            if (stall == 0) held = bus.out_data_o;
            checks++;
            if ({bus.in_ready_o, bus.out_valid_o} !== 2'b01 || bus.out_data_o !== held) begin
               errors++;
               $display("FAIL bp_stall%0d in_ready/out_valid=%b data %h required 01 data %h",
                        stall, {bus.in_ready_o, bus.out_valid_o}, bus.out_data_o, held);
            end
            stall++;
         end else if (stall == 3) begin
            checks++;
            if (bus.out_valid_o !== 1'b1) begin
               errors++;
               $display("FAIL bp_throughput out_valid got %b required 1", bus.out_valid_o);
            end
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            got_data.push_back(bus.out_data_o);
            got_last.push_back(bus.out_last_o);
            got_cf.push_back(bus.out_cf_o);
            if (bus.out_last_o) done = 1;
         end
         if (bus.in_valid_i && bus.in_ready_o) idx++;
      end
      checks++;
      if (!done || got_data.size() != exp_data.size()) begin
         errors++;
         $display("FAIL bp_count got %0d beats required %0d", got_data.size(), exp_data.size());
      end else begin
         for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if ({got_data[i], got_last[i], got_cf[i]} !== {exp_data[i], exp_last[i], exp_cf[i]}) begin
               errors++;
               $display("FAIL bp_beat%0d data/last/cf %h/%b/%b required %h/%b/%b", i,
                        got_data[i], got_last[i], got_cf[i], exp_data[i], exp_last[i], exp_cf[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      drive_idle();
      bus.out_ready_i  = 1'b0;
      bus.cmd_valid_i  = 1'b1;
      bus.cmd_shift_i  = 3'd2;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      bus.in_data_i   = 8'h5A;
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre out_valid got %b required 1", bus.out_valid_o);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid_o, bus.busy_o, bus.cmd_ready_o, bus.in_ready_o} !== 4'b0010 ||
          bus.out_data_o !== 8'h00) begin
         errors++;
         $display("FAIL midreset_post valid/busy/cmd_ready/in_ready=%b data %h required 0010 data 00",
                  {bus.out_valid_o, bus.busy_o, bus.cmd_ready_o, bus.in_ready_o}, bus.out_data_o);
      end
      for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
      run_op(0, 0, 4, 100, 100);
      checks++;
      if (timed_out || got_data.size() != 4) begin
         errors++;
         $display("FAIL midreset_passthru_count got %0d beats required 4", got_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if ({got_data[i], got_last[i], got_cf[i]} !== {words[i], i == 3, 1'b0}) begin
               errors++;
               $display("FAIL midreset_passthru%0d data/last/cf %h/%b/%b required %h/%b/0",
                        i, got_data[i], got_last[i], got_cf[i], words[i], i == 3);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_midstream();
      @(negedge clk);
      drive_idle();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/left_shift_stream_ctrl.md
Name: left_shift_stream_ctrl

Overview:
- Sequences one left_shift_unit instance to left-shift a multi-word operand that arrives as a word-serial stream, lowest word first.
- For each word, the instance's c_i is driven from the previous word, so the bits shifted out of word k-1 fill the vacated low bits of word k.
- A command supplies the shift amount and an optional extension word. Results leave through a registered valid/ready output stream.
- Sits between the ALU issue logic and the shift datapath for wide (multi-precision) shifts.

Parameters:
- WORD_WIDTH, 32, width of each data word and of the shifter; power of two, >= 4.
- OP_CHAIN, 2'b00, op_i code driven to left_shift_unit that selects "fill vacated bits from c_i".
- SW, $clog2(WORD_WIDTH), shift amount width (derived, not overridden).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_shift_i  in  SW  shift amount s, 0..WORD_WIDTH-1.
- cmd_extend_i  in  1  emit an extra top word holding the bits shifted out.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  input word accepted when high with in_valid_i.
- in_data_i  in  WORD_WIDTH  operand word, lowest word first.
- in_last_i  in  1  marks the final operand word.
- out_valid_o  out  1  result word valid.
- out_ready_i  in  1  consumer accepts the result word.
- out_data_o  out  WORD_WIDTH  result word.
- out_last_o  out  1  marks the final result word.
- out_cf_o  out  1  carry of this beat: last bit shifted out of the input word.
- busy_o  out  1  high while state != IDLE or out_valid_o.

Behaviour:
- Reset (rst_i sampled high on clk_i edge), from any state including mid-stream:
  - state = IDLE; out_valid_o = out_last_o = out_cf_o = 0; out_data_o = 0.
  - prev word = 0; latched s = 0; extend = 0.
  - Any in-flight output beat is discarded.
- Output register is free when out_valid_o == 0, or when out_ready_i == 1 in the same cycle.
- IDLE:
  - cmd_ready_o = 1; in_ready_o = 0; in_valid_i is ignored.
  - On cmd fire: latch s and extend, clear prev to 0, go to RUN. A pending output beat from the previous command may still drain.
- RUN:
  - cmd_ready_o = 0; in_ready_o = output register free.
  - On in fire, with d = in_data_i:
    - out_data_o <= (d << s) | (prev >> (WORD_WIDTH - s)); when s = 0, out_data_o <= d.
    - out_cf_o <= d[WORD_WIDTH - s] when s > 0, else 0.
    - out_valid_o <= 1; prev <= d.
  - If in_last_i = 1 and extend = 0: out_last_o <= 1, go to IDLE.
  - If in_last_i = 1 and extend = 1: out_last_o <= 0, go to EXT.
  - Otherwise out_last_o <= 0, stay in RUN.
- EXT:
  - cmd_ready_o = 0; in_ready_o = 0.
  - When the output register is free, load one beat and go to IDLE:
    - out_data_o <= prev >> (WORD_WIDTH - s); this is 0 when s = 0.
    - out_last_o <= 1; out_cf_o <= 0.
- Out fire with no new load: out_valid_o <= 0.
- Out fire and a new load in the same cycle: the new beat replaces the old one; no bubble.
- Latency: 1 cycle from in fire to out_valid_o. Throughput is 1 word per cycle while out_ready_i = 1.
- Stability: out_data_o, out_last_o and out_cf_o hold while out_valid_o = 1 and out_ready_i = 0.
- Shifter wiring:
  - Instance inputs: a_i = d; b_i[SW-1:0] = s; op_i = OP_CHAIN; c_i = prev[WORD_WIDTH-1:1].
  - The EXT beat reuses the instance with a_i = 0 and c_i = prev[WORD_WIDTH-1:1].
- A single-word operand (in_last_i on the first word) is legal.

Test Plan (WORD_WIDTH = 8):
1. cmd s=0, ext=0; words 0x12, 0x34(last) -> out 0x12, 0x34 (last on 2nd); cf 0, 0.
2. cmd s=4, ext=1; words 0xAB, 0xCD(last) -> out 0xB0, 0xDA, then 0x0C with last; cf 0, 0, 0.
3. cmd s=1, ext=0; word 0x80(last) -> out 0x00, cf=1, last=1; cmd_ready_o=1 the following cycle.
4. cmd s=7, ext=1; word 0xFF(last) -> out 0x80 (cf=1), then 0x7F (last=1, cf=0).
5. Backpressure: hold out_ready_i=0 for 3 cycles mid-stream -> out_data_o stable, in_ready_o=0, no word lost or duplicated; afterwards one word per cycle with out_ready_i=1.
6. Assert rst_i during RUN with out_valid_o=1 -> next cycle out_valid_o=0, busy_o=0, cmd_ready_o=1; a following s=0 command passes words through unchanged.
